// File: rtl/column_stream_reader_if.sv
// Valid/ready stream carrying node amplitudes with their scan offset and an end-of-scan flag.
interface column_stream_reader_if #(
  parameter int unsigned DATA_W = 18,
  parameter int unsigned ADDR_W = 9
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic              out_last;

  modport master (
    output out_data,
    output out_valid,
    output out_index,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    input  out_index,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/column_stream_reader.sv
// Streams a node column out of a pipelined M10K in address order, using credit-limited reads.
// Define COLUMN_READER_PEAK_EN to add the peak_abs output (max |u| over the accepted scan).
module column_stream_reader #(
  parameter int unsigned DATA_W     = 18,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_50,
  input  logic                 reset,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W-1:0]    length,
  output logic                 busy,
  output logic                 done,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_rd_addr,
  input  logic [DATA_W-1:0]    mem_rd_data,
  column_stream_reader_if.master out_if
`ifdef COLUMN_READER_PEAK_EN
  ,
  output logic [DATA_W-1:0]    peak_abs
`endif
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 2;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] addr_q, len_q, idx_q;
  logic [RD_LAT-1:0] pipe_vld_q, pipe_last_q;
  logic [ADDR_W-1:0] pipe_idx_q [RD_LAT];

  logic [DATA_W-1:0]     fifo_data_q [FIFO_DEPTH];
  logic [ADDR_W-1:0]     fifo_idx_q  [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last_q;
  logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]       fifo_cnt_q, inflight;

  logic issue, push, pop, out_valid, last_issue, credit, start_acc;

  assign start_acc  = (state_q == StIdle) && start;
  assign last_issue = (idx_q == len_q - ADDR_W'(1));
  assign push       = pipe_vld_q[RD_LAT-1];
  assign out_valid  = (fifo_cnt_q != '0);
  assign pop        = out_valid && out_if.out_ready;

  // Reads still travelling through the M10K pipeline.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < int'(RD_LAT); i++) begin
      inflight = inflight + CntW'(pipe_vld_q[i]);
    end
  end

  // Every issued read already owns a FIFO slot, so backpressure can never overflow it.
  assign credit = (inflight + fifo_cnt_q) < CntW'(FIFO_DEPTH);

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = (length == '0) ? StDone : StIssue;
      end
      StIssue: begin
        if (credit) begin
          issue = 1'b1;
          if (last_issue) state_d = StDrain;
        end
      end
      StDrain: begin
        // Leave as the final word is popped so done follows the last handshake directly.
        if ((inflight == '0) && (fifo_cnt_q == CntW'(pop))) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign busy        = (state_q == StIssue) || (state_q == StDrain);
  assign done        = (state_q == StDone);
  assign mem_rd_en   = issue;
  assign mem_rd_addr = addr_q;

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      addr_q      <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      pipe_vld_q  <= '0;
      pipe_last_q <= '0;
      for (int i = 0; i < int'(RD_LAT); i++) pipe_idx_q[i] <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_idx_q[i]  <= '0;
      end
      fifo_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fifo_cnt_q  <= '0;
    end else begin
      if (start_acc) begin
        addr_q <= base_addr;
        len_q  <= length;
        idx_q  <= '0;
      end else if (issue) begin
        addr_q <= addr_q + ADDR_W'(1);
        idx_q  <= idx_q + ADDR_W'(1);
      end

      // Tag pipeline mirrors the M10K latency so each tag meets its data.
      pipe_vld_q[0]  <= issue;
      pipe_idx_q[0]  <= idx_q;
      pipe_last_q[0] <= last_issue;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_idx_q[i]  <= pipe_idx_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end

      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_rd_data;
        fifo_idx_q[wr_ptr_q]  <= pipe_idx_q[RD_LAT-1];
        fifo_last_q[wr_ptr_q] <= pipe_last_q[RD_LAT-1];
        wr_ptr_q              <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);

      if (push && !pop) begin
        fifo_cnt_q <= fifo_cnt_q + CntW'(1);
      end else if (!push && pop) begin
        fifo_cnt_q <= fifo_cnt_q - CntW'(1);
      end
    end
  end

  assign out_if.out_valid = out_valid;
  assign out_if.out_data  = fifo_data_q[rd_ptr_q];
  assign out_if.out_index = fifo_idx_q[rd_ptr_q];
  assign out_if.out_last  = fifo_last_q[rd_ptr_q];

`ifdef COLUMN_READER_PEAK_EN
  logic [DATA_W-1:0] head_data, head_abs, peak_q;

  assign head_data = fifo_data_q[rd_ptr_q];

  // The most negative code has no positive twin; clamp it to full scale.
  always_comb begin
    head_abs = head_data;
    if (head_data[DATA_W-1]) begin
      if (head_data == {1'b1, {(DATA_W-1){1'b0}}}) begin
        head_abs = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        head_abs = -head_data;
      end
    end
  end

  always_ff @(posedge clk_50 or negedge reset) begin
    if (!reset) begin
      peak_q <= '0;
    end else if (start_acc) begin
      peak_q <= '0;
    end else if (pop && (head_abs > peak_q)) begin
      peak_q <= head_abs;
    end
  end

  assign peak_abs = peak_q;
`endif

endmodule

// File: tb/tb_column_stream_reader.sv
// Directed bench for column_stream_reader against a 2-cycle registered M10K model.
module tb_column_stream_reader;
  localparam int DW = 18;
  localparam int AW = 9;

  logic          clk_50 = 1'b0;
  logic          reset  = 1'b1;
  logic          start  = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length    = '0;
  logic          busy, done, mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic [DW-1:0] mem_rd_data;
`ifdef COLUMN_READER_PEAK_EN
  logic [DW-1:0] peak_abs;
`endif

  column_stream_reader_if #(.DATA_W(DW), .ADDR_W(AW)) out_if ();

  column_stream_reader dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_if      (out_if)
`ifdef COLUMN_READER_PEAK_EN
    ,
    .peak_abs    (peak_abs)
`endif
  );

  always #5 clk_50 = ~clk_50;

  logic [DW-1:0] mem [512];
  logic [AW-1:0] mem_addr_r;
  always @(posedge clk_50) begin
    mem_addr_r  <= mem_rd_addr;
    mem_rd_data <= mem[mem_addr_r];
  end

  int cyc = 0;
  always @(posedge clk_50) cyc <= cyc + 1;

  // Monitor: samples mid-cycle, logs handshakes, reads and done pulses.
  logic [DW-1:0] hs_data [$];
  logic [AW-1:0] hs_idx  [$];
  logic          hs_last [$];
  int            hs_cyc  [$];
  logic [AW-1:0] rd_log  [$];
  int            done_cyc [$];
  int   n_valid_cyc = 0, stall_err = 0, iss_cnt = 0, acc_cnt = 0, max_pend = 0;
  logic prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  always @(negedge clk_50) begin
    int i_n, a_n;
    if (!reset) begin
      prev_stall <= 1'b0;
      iss_cnt    <= 0;
      acc_cnt    <= 0;
    end else begin
      i_n = iss_cnt + int'(mem_rd_en);
      a_n = acc_cnt + int'(out_if.out_valid && out_if.out_ready);
      iss_cnt <= i_n;
      acc_cnt <= a_n;
      if (i_n - a_n > max_pend) max_pend <= i_n - a_n;
      if (mem_rd_en) rd_log.push_back(mem_rd_addr);
      if (done) done_cyc.push_back(cyc);
      if (out_if.out_valid) n_valid_cyc <= n_valid_cyc + 1;
      if (out_if.out_valid && out_if.out_ready) begin
        hs_data.push_back(out_if.out_data);
        hs_idx.push_back(out_if.out_index);
        hs_last.push_back(out_if.out_last);
        hs_cyc.push_back(cyc);
      end
      if (prev_stall && (!out_if.out_valid || out_if.out_data != prev_data ||
                         out_if.out_index != prev_idx || out_if.out_last != prev_last)) begin
        stall_err <= stall_err + 1;
      end
      prev_stall <= out_if.out_valid && !out_if.out_ready;
      prev_data  <= out_if.out_data;
      prev_idx   <= out_if.out_index;
      prev_last  <= out_if.out_last;
    end
  end

  int n_vec = 0;
  int n_err = 0;
  int start_cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_word(input int a);
    if (a < 15) return DW'(a * 32'h1111);
    return '0;
  endfunction

  task automatic tick();
    @(posedge clk_50);
    #2;
  endtask

  task automatic start_scan(input int b, input int l);
    start     = 1'b1;
    base_addr = AW'(b);
    length    = AW'(l);
    tick();
    start     = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk_50);
      n++;
    end
    check_eq({tag, "_done_seen"}, 32'(done), 1);
    tick();
  endtask

  task automatic check_scan(input int hb, input int b, input int l, input string t);
    check_eq({t, "_count"}, hs_data.size() - hb, l);
    for (int k = 0; k < l; k++) begin
      int j;
      j = hb + k;
      if (j < hs_data.size()) begin
        check_eq($sformatf("%s_data%0d", t, k), 32'(hs_data[j]), 32'(exp_word((b + k) % 512)));
        check_eq($sformatf("%s_idx%0d", t, k), 32'(hs_idx[j]), k);
        check_eq($sformatf("%s_last%0d", t, k), 32'(hs_last[j]), (k == l - 1) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int hb, rb, db, nv, c;
    logic [5:0] pat3;
    pat3 = 6'b101001;
    for (int a = 0; a < 512; a++) mem[a] = exp_word(a);
    out_if.out_ready = 1'b1;
    #1 reset = 1'b0;
    tick();
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_rden", 32'(mem_rd_en), 0);
    check_eq("rst_valid", 32'(out_if.out_valid), 0);
    check_eq("rst_addr", 32'(mem_rd_addr), 0);
    check_eq("rst_data", 32'(out_if.out_data), 0);
    check_eq("rst_index", 32'(out_if.out_index), 0);
    check_eq("rst_last", 32'(out_if.out_last), 0);
    reset = 1'b1;
    tick();

    // Full-rate scan across the populated words and beyond.
    hb = hs_data.size();
    start_scan(0, 30);
    check_eq("t1_busy", 32'(busy), 1);
    wait_done(200, "t1");
    check_eq("t1_done_pulse", 32'(done), 0);
    check_scan(hb, 0, 30, "t1");
    if (hs_cyc.size() > hb) check_eq("t1_latency", hs_cyc[hb] - start_cyc, 3);
    if (hs_cyc.size() > 0 && done_cyc.size() > 0)
      check_eq("t1_done_gap", done_cyc[done_cyc.size()-1] - hs_cyc[hs_cyc.size()-1], 1);
`ifdef COLUMN_READER_PEAK_EN
    check_eq("t1_peak", 32'(peak_abs), 32'h0EEEE);
`endif

    // Address wrap at the top of the M10K.
    hb = hs_data.size();
    rb = rd_log.size();
    start_scan(9'h1FE, 4);
    wait_done(100, "t2");
    check_eq("t2_nreads", rd_log.size() - rb, 4);
    if (rd_log.size() >= rb + 4) begin
      check_eq("t2_rd0", 32'(rd_log[rb]), 32'h1FE);
      check_eq("t2_rd1", 32'(rd_log[rb+1]), 32'h1FF);
      check_eq("t2_rd2", 32'(rd_log[rb+2]), 32'h000);
      check_eq("t2_rd3", 32'(rd_log[rb+3]), 32'h001);
    end
    check_scan(hb, 9'h1FE, 4, "t2");

    // Backpressure: toggled ready, then a long stall to exhaust credit.
    hb = hs_data.size();
    start_scan(0, 8);
    c = 0;
    while (c < 100) begin
      out_if.out_ready = (c < 6) ? pat3[c] : ((c < 16) ? 1'b0 : 1'b1);
      @(negedge clk_50);
      if (done) break;
      tick();
      c++;
    end
    check_eq("t3_done_seen", 32'(done), 1);
    tick();
    out_if.out_ready = 1'b1;
    check_scan(hb, 0, 8, "t3");
    check_eq("t3_stall_stable", stall_err, 0);
    check_eq("t3_pending_le4", (max_pend <= 4) ? 1 : 0, 1);

    // Zero-length scan, then a start ignored mid-scan.
    hb = hs_data.size();
    rb = rd_log.size();
    nv = n_valid_cyc;
    start_scan(0, 0);
    check_eq("t4_done_now", 32'(done), 1);
    check_eq("t4_busy_low", 32'(busy), 0);
    tick();
    check_eq("t4_done_once", 32'(done), 0);
    repeat (3) tick();
    check_eq("t4_no_reads", rd_log.size() - rb, 0);
    check_eq("t4_no_valid", n_valid_cyc - nv, 0);
    hb = hs_data.size();
    db = done_cyc.size();
    start_scan(0, 20);
    repeat (4) tick();
    start_scan(5, 3);
    check_eq("t4_still_busy", 32'(busy), 1);
    wait_done(200, "t4");
    repeat (6) tick();
    check_scan(hb, 0, 20, "t4b");
    check_eq("t4_one_done", done_cyc.size() - db, 1);

    // Asynchronous reset mid-scan, then a short fresh scan.
    hb = hs_data.size();
    start_scan(0, 30);
    c = 0;
    while (hs_data.size() < hb + 5 && c < 100) begin
      @(negedge clk_50);
      c++;
    end
    check_eq("t5_five_words", (hs_data.size() >= hb + 5) ? 1 : 0, 1);
    tick();
    reset = 1'b0;
    #1;
    check_eq("t5_rst_busy", 32'(busy), 0);
    check_eq("t5_rst_rden", 32'(mem_rd_en), 0);
    check_eq("t5_rst_valid", 32'(out_if.out_valid), 0);
    check_eq("t5_rst_addr", 32'(mem_rd_addr), 0);
    check_eq("t5_rst_data", 32'(out_if.out_data), 0);
    check_eq("t5_rst_index", 32'(out_if.out_index), 0);
    tick();
    reset = 1'b1;
    tick();
    check_eq("t5_idle_valid", 32'(out_if.out_valid), 0);
    hb = hs_data.size();
    start_scan(3, 2);
    wait_done(100, "t5");
    repeat (5) tick();
    check_scan(hb, 3, 2, "t5");

`ifdef COLUMN_READER_PEAK_EN
    mem[7] = 18'h20000;
    start_scan(0, 10);
    wait_done(100, "t6");
    check_eq("t6_peak_sat", 32'(peak_abs), 32'h1FFFF);
    mem[7] = exp_word(7);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
